register_resetless: RTL and testbench

- Parameterised-width, clock-enabled data register for the single-cycle processor datapath.
- Captures an input word on the rising clock edge when enabled. Drives it continuously until the next enabled edge.
- Used to stage the data-memory word address and write data ahead of the memory array, with the enable tied high.
- Optional DEPTH parameter chains several enabled stages to form an N-cycle delay line.
- Despite its name, this block has an asynchronous active-high reset that clears every stage.

---
 rtl/register_resetless.sv | 60 ++++++
 tb/tb_register_resetless.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/register_resetless.sv
// register_resetless: clock-enabled data register for the single-cycle datapath.
// DEPTH cascaded stages of BIT_WIDTH bits form a delay line of DEPTH enabled
// cycles. Stage 0 takes dataIn and the last stage drives dataOut directly from
// the flops. Despite its name, an asynchronous active-high reset loads
// RESET_VALUE into every stage.
module register_resetless #(
    parameter int                   BIT_WIDTH   = 32,
    parameter int                   DEPTH       = 1,
    parameter logic [BIT_WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 wrEn,
    input  logic [BIT_WIDTH-1:0] dataIn,
    output logic [BIT_WIDTH-1:0] dataOut
);

    localparam int CHAIN_W = DEPTH * BIT_WIDTH;

    // All stages packed into one vector. Stage k occupies
    // [k*BIT_WIDTH +: BIT_WIDTH], so stage 0 sits in the LSBs and the
    // output stage sits in the MSBs.
    logic [CHAIN_W-1:0] chain_q;
    logic [CHAIN_W-1:0] chain_d;
    logic [CHAIN_W-1:0] shift_in;

    // The shifted view moves every stage up one slot and inserts dataIn at
    // stage 0. A single-stage register has no lower stages to keep, so it
    // needs its own branch.
    generate
        if (DEPTH == 1) begin : g_single
            assign shift_in = dataIn;
        end else begin : g_chain
            assign shift_in = {chain_q[CHAIN_W-BIT_WIDTH-1:0], dataIn};
        end
    endgenerate

    // Next state: advance every stage together when enabled, otherwise hold.
    // NOTE: a complete assignment on both branches means no latch is inferred.
    always_comb begin
        chain_d = wrEn ? shift_in : chain_q;
    end

    // Stage register: asynchronous clear of every stage, enabled shift otherwise.
    // NOTE: every stage is reset, not only the output stage. A reset must flush
    //       words that are still in flight. Non-blocking assignment gives all
    //       stages simultaneous shift semantics.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            chain_q <= {DEPTH{RESET_VALUE}};
        end else begin
            chain_q <= chain_d;
        end
    end

    // Output comes straight from the last stage, so there is no
    // combinational path from dataIn to dataOut.
    assign dataOut = chain_q[CHAIN_W-1 -: BIT_WIDTH];

endmodule

// File: tb/tb_register_resetless.sv
// tb_register_resetless: scoreboard bench for register_resetless.
// Four instances share one stimulus stream:
//   u_d1: 32-bit, DEPTH 1
//   u_d3: 32-bit, DEPTH 3, reset value 0x5A5A5A5A
//   u_w1: 1-bit, DEPTH 1
//   u_w8: 8-bit, DEPTH 1
// The reference model records every word accepted at an enabled edge since
// the last reset. Each instance is then expected to show the word accepted
// DEPTH enabled edges ago, or its reset value while fewer than DEPTH words
// have been accepted.
module tb_register_resetless;

    localparam int          NDUT = 4;
    localparam int          DEP  [NDUT] = '{1, 3, 1, 1};
    localparam logic [31:0] MSK  [NDUT] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1, 32'hFF};
    localparam logic [31:0] RV   [NDUT] = '{32'h0, 32'h5A5A_5A5A, 32'h0, 32'h0};

    typedef struct {
        string       tag;
        logic [31:0] val [NDUT];
    } exp_t;

    logic        clk;
    logic        reset;
    logic        wrEn;
    logic [31:0] dataIn;
    logic [31:0] out_d1;
    logic [31:0] out_d3;
    logic        out_w1;
    logic [7:0]  out_w8;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] hist [$];
    exp_t        exp_q [$];

    register_resetless #(.BIT_WIDTH(32), .DEPTH(1), .RESET_VALUE(32'h0)) u_d1 (
        .clk(clk), .reset(reset), .wrEn(wrEn), .dataIn(dataIn), .dataOut(out_d1));
    register_resetless #(.BIT_WIDTH(32), .DEPTH(3), .RESET_VALUE(32'h5A5A_5A5A)) u_d3 (
        .clk(clk), .reset(reset), .wrEn(wrEn), .dataIn(dataIn), .dataOut(out_d3));
    register_resetless #(.BIT_WIDTH(1), .DEPTH(1), .RESET_VALUE(1'b0)) u_w1 (
        .clk(clk), .reset(reset), .wrEn(wrEn), .dataIn(dataIn[0]), .dataOut(out_w1));
    register_resetless #(.BIT_WIDTH(8), .DEPTH(1), .RESET_VALUE(8'h0)) u_w8 (
        .clk(clk), .reset(reset), .wrEn(wrEn), .dataIn(dataIn[7:0]), .dataOut(out_w8));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference value for instance i from the accepted-word history.
    function automatic logic [31:0] model_out(input int i);
        if (hist.size() >= DEP[i]) begin
            return hist[hist.size() - DEP[i]] & MSK[i];
        end
        return RV[i];
    endfunction

    // Called just after a posedge (+2). Drives the inputs and applies an
    // asserted reset to the model at once, because the reset acts
    // asynchronously. Then queues the state expected at the following
    // negedge, waits for the posedge and applies an enabled load to the
    // model.
    task automatic cyc(input string tag, input bit rst, input bit we, input logic [31:0] d);
        exp_t e;
        reset  = rst;
        wrEn   = we;
        dataIn = d;
        if (rst) hist.delete();
        e.tag = tag;
        for (int i = 0; i < NDUT; i++) e.val[i] = model_out(i);
        exp_q.push_back(e);
        @(posedge clk);
        if (!rst && we) hist.push_back(d);
        #2;
    endtask

    // Monitor: at every negedge, pop one expectation and compare all four
    // instances against it.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check({e.tag, "/d1"}, out_d1, e.val[0]);
                check({e.tag, "/d3"}, out_d3, e.val[1]);
                check({e.tag, "/w1"}, {31'b0, out_w1}, e.val[2]);
                check({e.tag, "/w8"}, {24'b0, out_w8}, e.val[3]);
            end
        end
    end

    initial begin
        logic [31:0] seq [4];

        reset  = 1'b1;
        wrEn   = 1'b0;
        dataIn = '0;
        @(posedge clk);
        #2;

        // Reset state, including an enabled edge that happens during reset.
        cyc("rst0", 1'b1, 1'b0, 32'h0);
        cyc("rst_we", 1'b1, 1'b1, 32'hDEAD_BEEF);

        // Async reset clears a loaded 0xDEADBEEF between edges.
        cyc("ld_dead", 1'b0, 1'b1, 32'hDEAD_BEEF);
        cyc("show_dead", 1'b0, 1'b0, 32'h0);
        cyc("async_rst", 1'b1, 1'b0, 32'h0);

        // Load, then hold for three edges.
        cyc("load", 1'b0, 1'b1, 32'h1234_5678);
        for (int k = 0; k < 3; k++) cyc("hold", 1'b0, 1'b0, 32'hFFFF_FFFF);
        cyc("hold_end", 1'b0, 1'b0, 32'h0);

        // Enable tied high, consecutive words.
        for (int k = 1; k <= 3; k++) cyc("tied_hi", 1'b0, 1'b1, k);

        // Delay line A..D with one hold edge mid-stream.
        seq = '{32'hA, 32'hB, 32'hC, 32'hD};
        cyc("dl_a", 1'b0, 1'b1, seq[0]);
        cyc("dl_b", 1'b0, 1'b1, seq[1]);
        cyc("dl_hold", 1'b0, 1'b0, 32'hEEEE_EEEE);
        cyc("dl_c", 1'b0, 1'b1, seq[2]);
        cyc("dl_d", 1'b0, 1'b1, seq[3]);
        for (int k = 0; k < 4; k++) cyc("dl_drain", 1'b0, 1'b1, 32'h100 + k);

        // Reset mid-stream with A/B/C in flight. After release the reset
        // value persists for three enabled edges, with a hold interleaved.
        for (int k = 0; k < 3; k++) cyc("mid_fill", 1'b0, 1'b1, seq[k]);
        cyc("mid_rst", 1'b1, 1'b1, 32'h77);
        cyc("mid_n1", 1'b0, 1'b1, 32'h11);
        cyc("mid_hold", 1'b0, 1'b0, 32'h99);
        cyc("mid_n2", 1'b0, 1'b1, 32'h22);
        cyc("mid_n3", 1'b0, 1'b1, 32'h33);
        cyc("mid_n4", 1'b0, 1'b1, 32'h44);
        cyc("mid_n5", 1'b0, 1'b0, 32'h0);

        // Edge widths: toggle bit 0 for the 1-bit instance, then 0x80 for
        // the 8-bit instance, which must show no sign extension.
        for (int k = 0; k < 6; k++) cyc("w1_tog", 1'b0, 1'b1, k & 1);
        cyc("w8_80", 1'b0, 1'b1, 32'h80);
        cyc("w8_show", 1'b0, 1'b0, 32'h0);

        // Randomized: mostly enabled edges, occasional holds and resets.
        for (int k = 0; k < 300; k++) begin
            cyc("rand", ($urandom_range(0, 24) == 0), ($urandom_range(0, 3) != 0), $urandom);
        end
        cyc("final", 1'b0, 1'b0, 32'h0);

        @(negedge clk);
        #1;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_pass++;
        end else begin
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
